// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             iord;
  logic             memwrite;
  logic             irwrite;
  logic             regwrite;
  logic             regdst;
  logic             memtoreg;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsrc;
  logic             pcen;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport ctrl (
    input  op, funct, zero, mem_ready,
    output iord, memwrite, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op, state, instret
  );

  modport dp (
    output op, funct, zero, mem_ready,
    input  iord, memwrite, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op, state, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback, stalls on mem_ready, flags illegal opcodes, counts retirements.
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_controller_if.ctrl bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  SLTIEX  = 4'd10, IMMWB  = 4'd11,
    JEX     = 4'd12, JREX    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             retire;
  logic [CNT_W-1:0] instret_q;

  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = (bus.funct == FN_JR) ? JREX : RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_SLTI:      state_d = SLTIEX;
          OP_J:         state_d = JEX;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR: begin
        state_d = bus.mem_ready ? FETCH : MEMWR;
        retire  = bus.mem_ready;
      end
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX, SLTIEX: state_d = IMMWB;
      MEMWB, RTYPEWB, BEQEX, IMMWB, JEX, JREX: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  logic pcwrite, branch;
  logic irwrite_raw, memwrite_raw, regwrite_raw;

  always_comb begin
    bus.iord     = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.aluop    = 2'b00;
    bus.pcsrc    = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    case (state_q)
      FETCH: begin
        bus.alusrcb = 2'b01;
        irwrite_raw = bus.mem_ready;
        pcwrite     = bus.mem_ready;
      end
      DECODE:  bus.alusrcb = 2'b11;
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD:   bus.iord = 1'b1;
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_raw = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        memwrite_raw = 1'b1;
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      RTYPEWB: begin
        bus.regdst   = 1'b1;
        regwrite_raw = 1'b1;
      end
      BEQEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      ADDIEX, SLTIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.aluop   = (state_q == SLTIEX) ? 2'b11 : 2'b00;
      end
      IMMWB:   regwrite_raw = 1'b1;
      JEX: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      JREX: begin
        bus.pcsrc = 2'b11;
        pcwrite   = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are masked by reset itself: state already reads FETCH while
  // reset is low, so mem_ready alone would otherwise leak irwrite/pcen.
  assign bus.irwrite    = irwrite_raw  & reset;
  assign bus.memwrite   = memwrite_raw & reset;
  assign bus.regwrite   = regwrite_raw & reset;
  assign bus.pcen       = (pcwrite | (branch & bus.zero)) & reset;
  assign bus.illegal_op = illegal_q;
  assign bus.state      = state_q;
  assign bus.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: per-instruction state sequences and per-state output table
// form the reference; a negedge process compares every cycle.
module tb_multicycle_controller;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();
  multicycle_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        exp_valid = 1'b0;
  int          exp_state;
  logic [14:0] exp_vec;
  logic        exp_ill;
  logic [31:0] exp_instret;
  int          retired = 0;
  logic        pend_ill = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // {iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,aluop,pcsrc,pcen}
  function automatic logic [14:0] act_vec();
    return {bus.iord, bus.memwrite, bus.irwrite, bus.regwrite, bus.regdst, bus.memtoreg,
            bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.pcen};
  endfunction

  function automatic logic [14:0] exp_out(input int s, input logic mr, input logic z);
    logic iord, mw, irw, rw, rd, mtr, asa, pcen;
    logic [1:0] asb, aop, psrc;
    {iord, mw, irw, rw, rd, mtr, asa, pcen} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin asb = 2'b01; irw = mr; pcen = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  iord = 1'b1;
      4:  begin mtr = 1'b1; rw = 1'b1; end
      5:  begin iord = 1'b1; mw = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pcen = z; end
      9:  begin asa = 1'b1; asb = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
      11: rw = 1'b1;
      12: begin psrc = 2'b10; pcen = 1'b1; end
      13: begin psrc = 2'b11; pcen = 1'b1; end
      default: ;
    endcase
    return {iord, mw, irw, rw, rd, mtr, asa, asb, aop, psrc, pcen};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h0a, 6'h02};
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("state", 32'(bus.state), 32'(exp_state));
      chk("outputs", 32'(act_vec()), 32'(exp_vec));
      chk("illegal_op", 32'(bus.illegal_op), 32'(exp_ill));
      chk("instret", bus.instret, exp_instret);
    end
  end

  // kind: 0 lw, 1 sw, 2 R-type, 3 jr, 4 beq, 5 addi, 6 slti, 7 j, 8 illegal.
  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input int kind, input int fw, input int mw, input int zmode,
                           output int memw);
    int          seq[$];
    logic [5:0]  op;
    logic [5:0]  fn;
    int          waits;
    logic        mr, z, stall_state;
    memw = 0;
    fn   = 6'($urandom);
    op   = 6'h00;
    case (kind)
      0: begin op = 6'h23; seq = {0, 1, 2, 3, 4}; end
      1: begin op = 6'h2b; seq = {0, 1, 2, 5}; end
      2: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; seq = {0, 1, 6, 7}; end
      3: begin op = 6'h00; fn = 6'h08; seq = {0, 1, 13}; end
      4: begin op = 6'h04; seq = {0, 1, 8}; end
      5: begin op = 6'h08; seq = {0, 1, 9, 11}; end
      6: begin op = 6'h0a; seq = {0, 1, 10, 11}; end
      7: begin op = 6'h02; seq = {0, 1, 12}; end
      default: begin
        do op = 6'($urandom); while (is_legal(op));
        seq = {0, 1};
      end
    endcase
    bus.op    = op;
    bus.funct = fn;
    foreach (seq[i]) begin
      stall_state = (seq[i] == 0) || (seq[i] == 3) || (seq[i] == 5);
      waits = (seq[i] == 0) ? fw : ((seq[i] == 3 || seq[i] == 5) ? mw : 0);
      for (int w = 0; w <= waits; w++) begin
        mr = stall_state ? (w == waits) : 1'($urandom);
        z  = (zmode < 0) ? 1'($urandom) : zmode[0];
        bus.mem_ready = mr;
        bus.zero      = z;
        exp_state   = seq[i];
        exp_vec     = exp_out(seq[i], mr, z);
        exp_ill     = pend_ill && (i == 0) && (w == 0);
        exp_instret = 32'(retired);
        exp_valid   = 1'b1;
        @(negedge clk);
        if (bus.memwrite) memw++;
        @(posedge clk);
        #1;
      end
    end
    pend_ill = (kind >= 8);
    if (kind < 8) retired++;
  endtask

  initial begin
    int mwc;
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.op        = 6'h23;
    bus.funct     = 6'h00;
    bus.zero      = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_strobes", 32'({bus.irwrite, bus.pcen, bus.memwrite, bus.regwrite}), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_illegal", 32'(bus.illegal_op), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(0, 0, 0, -1, mwc);
    chk("lw_instret", bus.instret, 32'd1);
    run_instr(1, 0, 3, -1, mwc);
    chk("sw_memwrite_cycles", 32'(mwc), 32'd4);
    chk("sw_instret", bus.instret, 32'd2);
    run_instr(4, 0, 0, 1, mwc);
    run_instr(4, 1, 0, 0, mwc);
    run_instr(2, 0, 0, -1, mwc);
    run_instr(3, 0, 0, -1, mwc);
    run_instr(6, 0, 0, -1, mwc);
    run_instr(8, 0, 0, -1, mwc);
    chk("ill_pulse", 32'(bus.illegal_op), 32'd1);
    chk("ill_instret", bus.instret, 32'd7);
    run_instr(5, 2, 0, -1, mwc);
    run_instr(7, 0, 0, -1, mwc);

    for (int n = 0; n < 300; n++) begin
      run_instr(int'($urandom_range(0, 8)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), -1, mwc);
    end

    // Reset in the middle of a lw, while parked in MEMRD with mem_ready high.
    exp_valid     = 1'b0;
    bus.op        = 6'h23;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_state", 32'(bus.state), 32'd3);
    reset = 1'b0;
    #1;
    chk("midrst_state", 32'(bus.state), 32'd0);
    chk("midrst_strobes", 32'({bus.irwrite, bus.pcen, bus.memwrite, bus.regwrite}), 32'd0);
    chk("midrst_instret", bus.instret, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_state", 32'(bus.state), 32'd0);
    chk("midrst_no_wb", 32'(bus.regwrite), 32'd0);
    reset    = 1'b1;
    retired  = 0;
    pend_ill = 1'b0;
    for (int n = 0; n < 20; n++) begin
      run_instr(int'($urandom_range(0, 8)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), -1, mwc);
    end
    exp_valid = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
